dual_port_sync_ram: RTL and testbench
=====================================

// Module: dual_port_sync_ram
// PURPOSE
//  Parametrised simple-dual-port synchronous RAM: one write port and one read port, both on one clock.
//  Successor to the single-port tristate RAM: separate unidirectional data buses, byte-enable writes,
//  a selectable read/write collision mode, a read-valid strobe and a self-clearing init sweep after reset.
//  Used as operand/result storage for the calculator datapath.
// PARAMETERS
//  ADDR_WIDTH  4   address bits, both ports
//  DATA_WIDTH  32  word width; must be a multiple of 8
//  DEPTH       16  number of words; DEPTH <= 2**ADDR_WIDTH
//  RD_MODE     0   collision policy: 0 = read-first (old data), 1 = write-first (new data)
// PORTS
//  clk       in   1             clock, all logic on posedge
//  rst_n     in   1             asynchronous active-low reset
//  ready     out  1             high when the init sweep is done and requests are accepted
//  wr_en     in   1             write request
//  wr_addr   in   ADDR_WIDTH    write address
//  wr_data   in   DATA_WIDTH    write data
//  wr_be     in   DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i]
//  rd_en     in   1             read request
//  rd_addr   in   ADDR_WIDTH    read address
//  rd_data   out  DATA_WIDTH    read data; holds its last value between reads
//  rd_valid  out  1             one-cycle strobe marking rd_data as updated
//  addr_err  out  1             one-cycle strobe: an accepted request had an address >= DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0, async): ready=0, rd_data=0, rd_valid=0, addr_err=0; FSM -> CLEAR, clear_ptr=0.
//    Array contents are not reset by rst_n; the sweep zeroes them.
//  - FSM CLEAR: writes 0 to mem[clear_ptr] each cycle, clear_ptr++. The last write is at clear_ptr=DEPTH-1;
//    the next state is READY with ready=1. The sweep takes DEPTH cycles after rst_n rises.
//    In CLEAR, wr_en and rd_en are ignored: no write, no rd_valid, no addr_err.
//  - FSM READY: stays in READY until rst_n is asserted. Reset mid-sweep restarts the sweep from 0.
//  - Write: on a posedge with ready & wr_en & wr_addr<DEPTH, each byte with wr_be[i]=1 is updated.
//    wr_be=0 performs no update and raises no error.
//  - Read: on a posedge with ready & rd_en, the word is registered and appears at the next posedge.
//    rd_valid=1 for exactly that cycle. Latency 1; back-to-back reads give one result per cycle.
//  - Collision (same cycle, rd_addr==wr_addr, both accepted):
//    RD_MODE=0 returns the pre-write word.
//    RD_MODE=1 returns the merged word: new bytes where wr_be=1, old bytes elsewhere.
//  - Out of range (addr >= DEPTH):
//    Write: dropped; addr_err pulses next cycle.
//    Read: rd_data=0 and rd_valid=1 next cycle; addr_err pulses in the same cycle.
//    If both ports are out of range in the same cycle, one addr_err pulse is produced.
//  - Address compare uses the full ADDR_WIDTH with no wrap-around; DEPTH=2**ADDR_WIDTH gives no errors.
// CONFIGURATION
//  DPRAM_OUT_REG_EN defined:
//    Adds an output register stage: read latency 2, with rd_valid and addr_err (read) delayed to match.
//    The extra stage resets to 0 asynchronously; collision semantics are unchanged.
//    Write-path addr_err stays at 1 cycle; if it coincides with a delayed read error, one pulse.
//  DPRAM_OUT_REG_EN undefined: latency 1, as described above.
// STRUCTURE
//  dpram_pkg:
//    typedef enum logic {DPRAM_CLEAR, DPRAM_READY} dpram_state_t
//    localparam RD_FIRST=0, WR_FIRST=1
//    function be_merge(old, new, be) returning the byte-merged word, shared by the write path and collision bypass
//  Sub-module dpram_init_fsm: owns state, clear_ptr and ready, and outputs clear_we/clear_addr.
//  The top-level module muxes the clear write port against the user write port.
// TESTING
//  1 Release rst_n; sample ready -> ready=0 for 16 cycles, 1 on cycle 17; reads of addr 0..15 return 0.
//  2 Write 0xDEADBEEF to addr 3 with wr_be=4'b1111, then wr_be=4'b0101 with 0x11223344
//    -> reading addr 3 gives 0xDE22BE44 with rd_valid one cycle after rd_en.
//  3 Same cycle: write 0xAAAAAAAA to addr 5 (old 0x0) and read addr 5
//    -> RD_MODE=0 returns 0x0; RD_MODE=1 returns 0xAAAAAAAA.
//  4 DEPTH=12: write addr 13 -> addr_err pulse and memory unchanged;
//    read addr 14 -> rd_data=0, rd_valid=1, addr_err=1.
//  5 Assert rst_n at sweep cycle 7 -> outputs 0 immediately; after release, ready rises 16 cycles later.
//  6 Define DPRAM_OUT_REG_EN; issue 4 back-to-back reads of addrs 0..3
//    -> rd_valid high in cycles 2..5 with the data in order.

Source files
------------

// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types, collision-mode constants and the byte-merge helper
// used by dual_port_sync_ram and its init sweep FSM.
package dpram_pkg;

    typedef enum logic {
        DPRAM_CLEAR = 1'b0,
        DPRAM_READY = 1'b1
    } dpram_state_t;

    // Collision policy selectors for RD_MODE.
    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Widest word be_merge can handle. Callers zero-extend their operands
    // and truncate the result with size casts.
    localparam int DPRAM_MAX_DW = 256;
    localparam int DPRAM_MAX_BE = DPRAM_MAX_DW / 8;

    // Returns old_word with every byte whose enable bit is set replaced by
    // the matching byte of new_word.
    function automatic logic [DPRAM_MAX_DW-1:0] be_merge(
        input logic [DPRAM_MAX_DW-1:0] old_word,
        input logic [DPRAM_MAX_DW-1:0] new_word,
        input logic [DPRAM_MAX_BE-1:0] be
    );
        logic [DPRAM_MAX_DW-1:0] result;
        result = old_word;
        for (int i = 0; i < DPRAM_MAX_BE; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dpram_init_fsm.sv
// dpram_init_fsm: after reset, walks clear_ptr over every word so the top
// level can zero the array, then raises ready and stays there until the
// next reset. A reset mid-sweep restarts the walk from word 0.
module dpram_init_fsm
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    dpram_state_t          state;
    dpram_state_t          state_next;
    logic [ADDR_WIDTH-1:0] clear_ptr;

    // State register plus sweep pointer, which advances every CLEAR cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DPRAM_CLEAR;
            clear_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == DPRAM_CLEAR) begin
                clear_ptr <= clear_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Leave CLEAR once the last word has been written; READY is terminal.
    always_comb begin
        state_next = state;
        case (state)
            DPRAM_CLEAR: if (clear_ptr == LAST_ADDR) state_next = DPRAM_READY;
            DPRAM_READY: state_next = DPRAM_READY;
            default:     state_next = DPRAM_CLEAR;
        endcase
    end

    // Sweep owns the write port for the whole of CLEAR.
    always_comb begin
        clear_we   = (state == DPRAM_CLEAR);
        clear_addr = clear_ptr;
        ready      = (state == DPRAM_READY);
    end

endmodule

// File: rtl/dual_port_sync_ram.sv
// dual_port_sync_ram: simple-dual-port synchronous RAM with byte-enable
// writes, selectable read/write collision policy, read-valid strobe,
// address-range error strobe and a self-clearing init sweep.
// Optional build macro DPRAM_OUT_REG_EN adds an output register stage
// (read latency 2); without it the read latency is 1.
module dual_port_sync_ram
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int RD_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    ready,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    addr_err
);

    // One extra bit so DEPTH == 2**ADDR_WIDTH compares without wrapping.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_take;
    logic                  rd_take;
    logic                  wr_commit;
    logic                  collide;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] rd_data_s1;
    logic                  rd_valid_s1;
    logic                  rd_err_s1;
    logic                  wr_err_s1;

    dpram_init_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_init (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready      (ready),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    // Request qualification, byte merge and the read word including the write-first bypass.
    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < DEPTH_LIMIT);
        rd_in_range = ({1'b0, rd_addr} < DEPTH_LIMIT);
        wr_take     = ready & wr_en;
        rd_take     = ready & rd_en;
        wr_commit   = wr_take & wr_in_range;
        wr_old      = wr_in_range ? mem[wr_addr] : '0;
        wr_merged   = DATA_WIDTH'(be_merge(DPRAM_MAX_DW'(wr_old),
                                           DPRAM_MAX_DW'(wr_data),
                                           DPRAM_MAX_BE'(wr_be)));
        collide     = wr_commit & (wr_addr == rd_addr) & (RD_MODE == WR_FIRST);
        if (!rd_in_range) begin
            rd_word = '0;
        end else if (collide) begin
            rd_word = wr_merged;
        end else begin
            rd_word = mem[rd_addr];
        end
    end

    // Single physical write port: the init sweep owns it until ready, then user writes.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else if (wr_commit) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    // First read stage plus one-cycle error strobes; rd_data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_s1  <= '0;
            rd_valid_s1 <= 1'b0;
            rd_err_s1   <= 1'b0;
            wr_err_s1   <= 1'b0;
        end else begin
            rd_valid_s1 <= rd_take;
            rd_err_s1   <= rd_take & ~rd_in_range;
            wr_err_s1   <= wr_take & ~wr_in_range;
            if (rd_take) begin
                rd_data_s1 <= rd_word;
            end
        end
    end

`ifdef DPRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] rd_data_s2;
    logic                  rd_valid_s2;
    logic                  rd_err_s2;

    // Output stage delays read data, valid and read error by one more cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_s2  <= '0;
            rd_valid_s2 <= 1'b0;
            rd_err_s2   <= 1'b0;
        end else begin
            rd_valid_s2 <= rd_valid_s1;
            rd_err_s2   <= rd_err_s1;
            if (rd_valid_s1) begin
                rd_data_s2 <= rd_data_s1;
            end
        end
    end

    assign rd_data  = rd_data_s2;
    assign rd_valid = rd_valid_s2;
    assign addr_err = rd_err_s2 | wr_err_s1;
`else
    assign rd_data  = rd_data_s1;
    assign rd_valid = rd_valid_s1;
    assign addr_err = rd_err_s1 | wr_err_s1;
`endif

endmodule

// File: tb/tb_dual_port_sync_ram.sv
// tb_dual_port_sync_ram: drives three instances (read-first DEPTH 16,
// write-first DEPTH 16, read-first DEPTH 12) with shared stimulus and
// compares each against a per-instance word-level memory model.
// Honours DPRAM_OUT_REG_EN for the expected read latency.
`timescale 1ns/1ps
module tb_dual_port_sync_ram;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int BEW  = DW / 8;
    localparam int NDUT = 3;
    localparam int HIST = 4096;
`ifdef DPRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [BEW-1:0] wr_be  = '0;

    logic [NDUT-1:0]         ready_o;
    logic [NDUT-1:0]         rd_valid_o;
    logic [NDUT-1:0]         addr_err_o;
    logic [NDUT-1:0][DW-1:0] rd_data_o;

    // Reference model state
    logic [DW-1:0] mem_m [NDUT][16];
    bit            ready_m [NDUT];
    int            sweep_cnt [NDUT];
    bit            h_valid [HIST][NDUT];
    bit            h_rerr  [HIST][NDUT];
    bit            h_werr  [HIST][NDUT];
    logic [DW-1:0] h_data  [HIST][NDUT];
    bit            exp_valid [NDUT];
    bit            exp_err   [NDUT];
    logic [DW-1:0] exp_data  [NDUT];
    int            cyc  = 0;
    int            base = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    dual_port_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .RD_MODE(0)) u_rf (
        .clk(clk), .rst_n(rst_n), .ready(ready_o[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[0]),
        .rd_valid(rd_valid_o[0]), .addr_err(addr_err_o[0])
    );

    dual_port_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .RD_MODE(1)) u_wf (
        .clk(clk), .rst_n(rst_n), .ready(ready_o[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[1]),
        .rd_valid(rd_valid_o[1]), .addr_err(addr_err_o[1])
    );

    dual_port_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(12), .RD_MODE(0)) u_d12 (
        .clk(clk), .rst_n(rst_n), .ready(ready_o[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[2]),
        .rd_valid(rd_valid_o[2]), .addr_err(addr_err_o[2])
    );

    function automatic int dep_of(input int k);
        return (k == 2) ? 12 : 16;
    endfunction

    function automatic bit write_first(input int k);
        return (k == 1);
    endfunction

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [BEW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BEW; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Assert reset (asynchronously) and bring the model to its post-reset view.
    task automatic assert_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            ready_m[k]   = 1'b0;
            sweep_cnt[k] = 0;
            exp_valid[k] = 1'b0;
            exp_err[k]   = 1'b0;
            exp_data[k]  = '0;
            for (int a = 0; a < 16; a++) mem_m[k][a] = '0;
        end
        base = cyc;
    endtask

    // One clock: record what each instance should do with the current inputs,
    // step the clock, and work out which results are visible now.
    task automatic tick();
        int ri;
        for (int k = 0; k < NDUT; k++) begin
            bit w_acc, r_acc, w_in, r_in;
            logic [DW-1:0] merged, result;
            w_acc  = ready_m[k] && (wr_en === 1'b1);
            r_acc  = ready_m[k] && (rd_en === 1'b1);
            w_in   = int'(wr_addr) < dep_of(k);
            r_in   = int'(rd_addr) < dep_of(k);
            merged = merge_bytes(mem_m[k][wr_addr], wr_data, wr_be);
            if (!r_in) result = '0;
            else if (w_acc && w_in && wr_addr == rd_addr && write_first(k)) result = merged;
            else result = mem_m[k][rd_addr];
            h_valid[cyc][k] = r_acc;
            h_data[cyc][k]  = result;
            h_rerr[cyc][k]  = r_acc && !r_in;
            h_werr[cyc][k]  = w_acc && !w_in;
            if (w_acc && w_in) mem_m[k][wr_addr] = merged;
        end
        @(posedge clk);
        if (rst_n === 1'b1) begin
            for (int k = 0; k < NDUT; k++) begin
                if (!ready_m[k]) begin
                    sweep_cnt[k]++;
                    if (sweep_cnt[k] >= dep_of(k)) ready_m[k] = 1'b1;
                end
            end
        end
        @(negedge clk);
        ri = cyc - (LAT - 1);
        for (int k = 0; k < NDUT; k++) begin
            exp_valid[k] = (ri >= base) && h_valid[ri][k];
            exp_err[k]   = ((ri >= base) && h_rerr[ri][k]) || h_werr[cyc][k];
            if (exp_valid[k]) exp_data[k] = h_data[ri][k];
        end
        cyc++;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        assert_reset();
        idle();
        repeat (3) begin
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (ready_o[k] !== ready_m[k] || rd_valid_o[k] !== exp_valid[k] ||
                    addr_err_o[k] !== exp_err[k] || rd_data_o[k] !== exp_data[k]) begin
                    errors++;
                    $display("[TB] FAIL reset_hold dut=%0d cyc=%0d got r=%b v=%b e=%b d=%h exp r=%b v=%b e=%b d=%h",
                             k, cyc, ready_o[k], rd_valid_o[k], addr_err_o[k], rd_data_o[k],
                             ready_m[k], exp_valid[k], exp_err[k], exp_data[k]);
                end
            end
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            checks++;
            if (ready_o[0] !== (n >= 16) || ready_o[2] !== (n >= 12)) begin
                errors++;
                $display("[TB] FAIL ready_rise n=%0d got rf=%b d12=%b exp rf=%b d12=%b",
                         n, ready_o[0], ready_o[2], (n >= 16), (n >= 12));
            end
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (ready_o[k] !== ready_m[k] || rd_valid_o[k] !== exp_valid[k] ||
                    addr_err_o[k] !== exp_err[k] || rd_data_o[k] !== exp_data[k]) begin
                    errors++;
                    $display("[TB] FAIL sweep dut=%0d cyc=%0d got r=%b v=%b e=%b d=%h exp r=%b v=%b e=%b d=%h",
                             k, cyc, ready_o[k], rd_valid_o[k], addr_err_o[k], rd_data_o[k],
                             ready_m[k], exp_valid[k], exp_err[k], exp_data[k]);
                end
            end
        end
        for (int a = 0; a < 16 + LAT; a++) begin
            rd_en   = (a < 16);
            rd_addr = AW'(a);
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (ready_o[k] !== ready_m[k] || rd_valid_o[k] !== exp_valid[k] ||
                    addr_err_o[k] !== exp_err[k] || rd_data_o[k] !== exp_data[k]) begin
                    errors++;
                    $display("[TB] FAIL cleared_read dut=%0d cyc=%0d got r=%b v=%b e=%b d=%h exp r=%b v=%b e=%b d=%h",
                             k, cyc, ready_o[k], rd_valid_o[k], addr_err_o[k], rd_data_o[k],
                             ready_m[k], exp_valid[k], exp_err[k], exp_data[k]);
                end
            end
        end
        idle();
    endtask

    task automatic test_byte_enable();
        logic [DW-1:0] wd [3] = '{32'hDEADBEEF, 32'h11223344, 32'hFFFFFFFF};
        logic [BEW-1:0] wb [3] = '{4'b1111, 4'b0101, 4'b0000};
        for (int i = 0; i < 3 + 1 + LAT; i++) begin
            idle();
            if (i < 3) begin
                wr_en = 1'b1; wr_addr = 4'd3; wr_data = wd[i]; wr_be = wb[i];
            end else if (i == 3) begin
                rd_en = 1'b1; rd_addr = 4'd3;
            end
            tick();
            if (i == 3 + LAT - 1) begin
                checks++;
                if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== 32'hDE22BE44) begin
                    errors++;
                    $display("[TB] FAIL be_merge got v=%b d=%h exp v=1 d=de22be44", rd_valid_o[0], rd_data_o[0]);
                end
            end
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (ready_o[k] !== ready_m[k] || rd_valid_o[k] !== exp_valid[k] ||
                    addr_err_o[k] !== exp_err[k] || rd_data_o[k] !== exp_data[k]) begin
                    errors++;
                    $display("[TB] FAIL byte_enable dut=%0d cyc=%0d got r=%b v=%b e=%b d=%h exp r=%b v=%b e=%b d=%h",
                             k, cyc, ready_o[k], rd_valid_o[k], addr_err_o[k], rd_data_o[k],
                             ready_m[k], exp_valid[k], exp_err[k], exp_data[k]);
                end
            end
        end
        idle();
    endtask

    task automatic test_collision();
        for (int i = 0; i < 3 + LAT; i++) begin
            idle();
            if (i == 0) begin
                wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hAAAAAAAA; wr_be = 4'b1111;
                rd_en = 1'b1; rd_addr = 4'd5;
            end else if (i == 1) begin
                wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h55667788; wr_be = 4'b0011;
                rd_en = 1'b1; rd_addr = 4'd5;
            end else if (i == 2) begin
                rd_en = 1'b1; rd_addr = 4'd5;
            end
            tick();
            if (i == LAT - 1) begin
                checks++;
                if (rd_data_o[0] !== 32'h0 || rd_data_o[1] !== 32'hAAAAAAAA ||
                    rd_valid_o[0] !== 1'b1 || rd_valid_o[1] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL collision got rf=%h wf=%h v=%b%b exp rf=00000000 wf=aaaaaaaa v=11",
                             rd_data_o[0], rd_data_o[1], rd_valid_o[0], rd_valid_o[1]);
                end
            end
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (ready_o[k] !== ready_m[k] || rd_valid_o[k] !== exp_valid[k] ||
                    addr_err_o[k] !== exp_err[k] || rd_data_o[k] !== exp_data[k]) begin
                    errors++;
                    $display("[TB] FAIL collision_seq dut=%0d cyc=%0d got r=%b v=%b e=%b d=%h exp r=%b v=%b e=%b d=%h",
                             k, cyc, ready_o[k], rd_valid_o[k], addr_err_o[k], rd_data_o[k],
                             ready_m[k], exp_valid[k], exp_err[k], exp_data[k]);
                end
            end
        end
        idle();
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 6 + LAT; i++) begin
            idle();
            wr_be = 4'b1111;
            case (i)
                0: begin wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'h12345678; end
                1: begin rd_en = 1'b1; rd_addr = 4'd14; end
                2: begin rd_en = 1'b1; rd_addr = 4'd13; end
                3: begin wr_en = 1'b1; wr_addr = 4'd12; wr_data = 32'hCAFEF00D;
                         rd_en = 1'b1; rd_addr = 4'd15; end
                4: begin rd_en = 1'b1; rd_addr = 4'd13; end
                5: begin wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'h0BADF00D; end
                default: ;
            endcase
            tick();
            if (i == 0) begin
                checks++;
                if (addr_err_o[2] !== 1'b1 || addr_err_o[0] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL wr_oor_err got d12=%b rf=%b exp d12=1 rf=0", addr_err_o[2], addr_err_o[0]);
                end
            end
            if (i == 1 + LAT - 1) begin
                checks++;
                if (rd_data_o[2] !== 32'h0 || rd_valid_o[2] !== 1'b1 || addr_err_o[2] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rd_oor got d=%h v=%b e=%b exp d=00000000 v=1 e=1",
                             rd_data_o[2], rd_valid_o[2], addr_err_o[2]);
                end
            end
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (ready_o[k] !== ready_m[k] || rd_valid_o[k] !== exp_valid[k] ||
                    addr_err_o[k] !== exp_err[k] || rd_data_o[k] !== exp_data[k]) begin
                    errors++;
                    $display("[TB] FAIL out_of_range dut=%0d cyc=%0d got r=%b v=%b e=%b d=%h exp r=%b v=%b e=%b d=%h",
                             k, cyc, ready_o[k], rd_valid_o[k], addr_err_o[k], rd_data_o[k],
                             ready_m[k], exp_valid[k], exp_err[k], exp_data[k]);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_sweep();
        idle();
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        idle();
        repeat (LAT) tick();
        #2;
        assert_reset();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (ready_o[k] !== 1'b0 || rd_data_o[k] !== '0 || rd_valid_o[k] !== 1'b0 || addr_err_o[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL async_reset dut=%0d got r=%b v=%b e=%b d=%h exp all zero",
                         k, ready_o[k], rd_valid_o[k], addr_err_o[k], rd_data_o[k]);
            end
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (7) tick();
        #2;
        assert_reset();
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            checks++;
            if (ready_o[0] !== (n >= 16)) begin
                errors++;
                $display("[TB] FAIL restart_ready n=%0d got %b exp %b", n, ready_o[0], (n >= 16));
            end
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (ready_o[k] !== ready_m[k] || rd_valid_o[k] !== exp_valid[k] ||
                    addr_err_o[k] !== exp_err[k] || rd_data_o[k] !== exp_data[k]) begin
                    errors++;
                    $display("[TB] FAIL restart_sweep dut=%0d cyc=%0d got r=%b v=%b e=%b d=%h exp r=%b v=%b e=%b d=%h",
                             k, cyc, ready_o[k], rd_valid_o[k], addr_err_o[k], rd_data_o[k],
                             ready_m[k], exp_valid[k], exp_err[k], exp_data[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got_q[$];
        for (int a = 0; a < 4; a++) begin
            idle();
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(32'h11111111 * (a + 1)); wr_be = 4'b1111;
            tick();
        end
        for (int n = 1; n <= LAT + 4; n++) begin
            idle();
            if (n <= 4) begin
                rd_en = 1'b1; rd_addr = AW'(n - 1);
            end
            tick();
            if (rd_valid_o[0] === 1'b1) got_q.push_back(rd_data_o[0]);
            checks++;
            if (rd_valid_o[0] !== ((n >= LAT) && (n <= LAT + 3))) begin
                errors++;
                $display("[TB] FAIL b2b_valid n=%0d got %b exp %b", n, rd_valid_o[0], ((n >= LAT) && (n <= LAT + 3)));
            end
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (ready_o[k] !== ready_m[k] || rd_valid_o[k] !== exp_valid[k] ||
                    addr_err_o[k] !== exp_err[k] || rd_data_o[k] !== exp_data[k]) begin
                    errors++;
                    $display("[TB] FAIL back_to_back dut=%0d cyc=%0d got r=%b v=%b e=%b d=%h exp r=%b v=%b e=%b d=%h",
                             k, cyc, ready_o[k], rd_valid_o[k], addr_err_o[k], rd_data_o[k],
                             ready_m[k], exp_valid[k], exp_err[k], exp_data[k]);
                end
            end
        end
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d exp 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== DW'(32'h11111111 * (i + 1))) begin
                    errors++;
                    $display("[TB] FAIL b2b_order idx=%0d got %h exp %h", i, got_q[i], DW'(32'h11111111 * (i + 1)));
                end
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 15));
            rd_addr = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rd_addr = wr_addr;
            wr_data = $urandom;
            wr_be   = BEW'($urandom_range(1, 15));
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (ready_o[k] !== ready_m[k] || rd_valid_o[k] !== exp_valid[k] ||
                    addr_err_o[k] !== exp_err[k] || rd_data_o[k] !== exp_data[k]) begin
                    errors++;
                    $display("[TB] FAIL random dut=%0d cyc=%0d got r=%b v=%b e=%b d=%h exp r=%b v=%b e=%b d=%h",
                             k, cyc, ready_o[k], rd_valid_o[k], addr_err_o[k], rd_data_o[k],
                             ready_m[k], exp_valid[k], exp_err[k], exp_data[k]);
                end
            end
        end
        idle();
    endtask

    initial begin
        $display("[TB] dual_port_sync_ram bench, read latency %0d", LAT);
        test_reset();
        test_byte_enable();
        test_collision();
        test_out_of_range();
        test_reset_mid_sweep();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog cyc=%0d got no finish exp finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
